alu_seq_ctrl: RTL and testbench

- Issue/sequencing controller placed between decode and the ALU.
- Accepts one data-processing or multiply instruction per handshake and evaluates its ARM condition code against an architectural NZCV flag register that it owns.
- Drives the ALU operand and command inputs from registered copies, holds multiply for a fixed latency, then presents the result on a valid/ready writeback port.
- Updates NZCV when the S bit is set.

---
 rtl/alu_ctrl_pkg.sv | 36 +++
 rtl/alu_seq_ctrl_if.sv | 43 ++++
 rtl/cond_check.sv | 38 +++
 rtl/alu_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared types, opcode/class constants and helpers for the ALU sequencer.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_XOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_MUL = 4'b0000;

  localparam logic [1:0] CLS_DP  = 2'b00;
  localparam logic [1:0] CLS_MUL = 2'b11;

  function automatic logic is_arith(input logic [3:0] opcode);
    return (opcode == OP_SUB) || (opcode == OP_RSB) ||
           (opcode == OP_ADD) || (opcode == OP_ADC);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - issue, ALU drive and writeback signals of the sequencer.
interface alu_seq_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              issue_valid;
  logic              issue_ready;
  logic [7:0]        issue_cmd;
  logic [3:0]        issue_cond;
  logic              issue_set_flags;
  logic [3:0]        issue_rd;
  logic [DATA_W-1:0] issue_op1;
  logic [DATA_W-1:0] issue_op2;

  logic [DATA_W-1:0] alu_src1;
  logic [DATA_W-1:0] alu_src2;
  logic [7:0]        alu_ctrl_cmd;
  logic [3:0]        alu_cur_flags;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_new_flags;

  logic              wb_valid;
  logic              wb_ready;
  logic [3:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;

  modport slave (
    input  issue_valid, issue_cmd, issue_cond, issue_set_flags, issue_rd, issue_op1, issue_op2,
    output issue_ready,
    output alu_src1, alu_src2, alu_ctrl_cmd, alu_cur_flags,
    input  alu_result, alu_new_flags,
    output wb_valid, wb_rd, wb_data,
    input  wb_ready
  );

  modport master (
    output issue_valid, issue_cmd, issue_cond, issue_set_flags, issue_rd, issue_op1, issue_op2,
    input  issue_ready,
    input  alu_src1, alu_src2, alu_ctrl_cmd, alu_cur_flags,
    output alu_result, alu_new_flags,
    input  wb_valid, wb_rd, wb_data,
    output wb_ready
  );
endinterface

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition-code evaluation against NZCV.
module cond_check
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);
  logic n, z, c, v;

  assign n = nzcv_i[3];
  assign z = nzcv_i[2];
  assign c = nzcv_i[1];
  assign v = nzcv_i[0];

  always_comb begin
    pass_o = 1'b0;
    case (cond_t'(cond_i))
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - issue/sequencing controller between decode and the ALU, owns NZCV.
// ALU_SEQ_OVF_EN: compute V locally for ADD/ADC/SUB/RSB; otherwise V is always retained.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_seq_ctrl_if.slave    bus,
  output logic [3:0]       flags,
  output logic             busy
);
  localparam int MSB = DATA_W - 1;
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [3:0]        rd_q, rd_d;
  logic              s_q, s_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        flags_q, flags_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [3:0]        wb_rd_q, wb_rd_d;

  logic cond_pass;
  logic c_next, v_next;
  logic unused_alu_v;

  cond_check u_cond (
    .cond_i (bus.issue_cond),
    .nzcv_i (flags_q),
    .pass_o (cond_pass)
  );

  // The ALU's V output is never trusted: either retained or recomputed below.
  assign unused_alu_v = bus.alu_new_flags[0];

  assign c_next = ((cmd_q[7:6] == CLS_DP) && is_arith(cmd_q[4:1])) ? bus.alu_new_flags[1]
                                                                   : flags_q[1];

`ifdef ALU_SEQ_OVF_EN
  logic a_msb, b_msb, ovf_op;
  always_comb begin
    a_msb  = op1_q[MSB];
    b_msb  = op2_q[MSB];
    ovf_op = 1'b0;
    if (cmd_q[7:6] == CLS_DP) begin
      case (cmd_q[4:1])
        OP_ADD, OP_ADC: ovf_op = 1'b1;
        OP_SUB: begin
          b_msb  = ~op2_q[MSB];
          ovf_op = 1'b1;
        end
        OP_RSB: begin
          a_msb  = op2_q[MSB];
          b_msb  = ~op1_q[MSB];
          ovf_op = 1'b1;
        end
        default: ovf_op = 1'b0;
      endcase
    end
    v_next = ovf_op ? ((a_msb == b_msb) && (bus.alu_result[MSB] != a_msb)) : flags_q[0];
  end
`else
  assign v_next = flags_q[0];
`endif

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    rd_d       = rd_q;
    s_d        = s_q;
    cnt_d      = cnt_q;
    flags_d    = flags_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    case (state_q)
      IDLE: begin
        // A failed condition consumes the slot with no side effects.
        if (bus.issue_valid && cond_pass) begin
          cmd_d   = bus.issue_cmd;
          op1_d   = bus.issue_op1;
          op2_d   = bus.issue_op2;
          rd_d    = bus.issue_rd;
          s_d     = bus.issue_set_flags;
          cnt_d   = (bus.issue_cmd[7:6] == CLS_MUL) ? MUL_LAST : 4'd0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          wb_data_d  = bus.alu_result;
          wb_rd_d    = rd_q;
          wb_valid_d = 1'b1;
          state_d    = WB;
          if (s_q) begin
            flags_d = {bus.alu_new_flags[3], bus.alu_new_flags[2], c_next, v_next};
          end
        end
      end
      WB: begin
        if (bus.wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      rd_q       <= '0;
      s_q        <= 1'b0;
      cnt_q      <= '0;
      flags_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      rd_q       <= rd_d;
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      flags_q    <= flags_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  assign bus.issue_ready   = (state_q == IDLE);
  assign bus.alu_src1      = op1_q;
  assign bus.alu_src2      = op2_q;
  assign bus.alu_ctrl_cmd  = cmd_q;
  assign bus.alu_cur_flags = flags_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.wb_rd         = wb_rd_q;
  assign flags             = flags_q;
  assign busy              = (state_q != IDLE);
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed and randomized checks of alu_seq_ctrl against a reference model.
module tb_alu_seq_ctrl;
  import alu_ctrl_pkg::*;

  localparam int DATA_W     = 32;
  localparam int MUL_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] flags;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] mflags = 4'b0000;
  logic       alu_noise_c = 1'b0;
  logic       alu_noise_v = 1'b0;
  logic [32:0] alu_out;

  alu_seq_ctrl_if #(.DATA_W(DATA_W)) bus ();

  alu_seq_ctrl #(.DATA_W(DATA_W), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .flags (flags),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // ALU device model: {carry, result}; non-arithmetic carry/V outputs are deliberately wrong.
  function automatic logic [32:0] alu_fn(input logic [7:0] cmd, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin);
    logic [63:0] p;
    if (cmd[7:6] == 2'b11) begin
      p = {32'b0, a} * {32'b0, b};
      return {1'b0, p[31:0]};
    end
    case (cmd[4:1])
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a ^ b};
      4'b0010: return {1'b0, a} + {1'b0, ~b} + 33'd1;
      4'b0011: return {1'b0, b} + {1'b0, ~a} + 33'd1;
      4'b0100: return {1'b0, a} + {1'b0, b};
      4'b0101: return {1'b0, a} + {1'b0, b} + {32'b0, cin};
      4'b1100: return {1'b0, a | b};
      4'b1110: return {1'b0, a & ~b};
      4'b1111: return {1'b0, ~b};
      default: return 33'd0;
    endcase
  endfunction

  function automatic logic tb_arith(input logic [7:0] cmd);
    return (cmd[7:6] == 2'b00) && (cmd[4:1] >= 4'd2) && (cmd[4:1] <= 4'd5);
  endfunction

  assign alu_out = alu_fn(bus.alu_ctrl_cmd, bus.alu_src1, bus.alu_src2, bus.alu_cur_flags[1]);
  assign bus.alu_result = alu_out[31:0];
  assign bus.alu_new_flags = {alu_out[31], (alu_out[31:0] == 32'd0),
                              tb_arith(bus.alu_ctrl_cmd) ? alu_out[32] : alu_noise_c,
                              alu_noise_v};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_instr(input logic [1:0] cls, input logic [3:0] op, input logic [3:0] cond,
                           input logic s, input logic [3:0] rd, input logic [31:0] a,
                           input logic [31:0] b, input int wb_delay);
    logic [7:0]  cmd;
    logic        pass, arith;
    logic [31:0] res;
    logic [63:0] p;
    longint      sa, sb, sv;
    logic        n, z, c, v;
    logic [3:0]  nflags;
    int          ecyc;
    cmd  = {cls, 1'b0, op, 1'b0};
    pass = cond_ok(cond, mflags);
    sa = $signed(a);
    sb = $signed(b);
    {n, z, c, v} = mflags;
    arith = 1'b0;
    sv = 0;
    res = 32'd0;
    if (cls == CLS_MUL) begin
      p = {32'b0, a} * {32'b0, b};
      res = p[31:0];
    end else begin
      case (op)
        OP_AND: res = a & b;
        OP_XOR: res = a ^ b;
        OP_ORR: res = a | b;
        OP_BIC: res = a & ~b;
        OP_MVN: res = ~b;
        OP_SUB: begin res = a - b; c = (a >= b); sv = sa - sb; arith = 1'b1; end
        OP_RSB: begin res = b - a; c = (b >= a); sv = sb - sa; arith = 1'b1; end
        OP_ADD: begin
          res = a + b; c = ({1'b0, a} + {1'b0, b}) > 33'h0FFFFFFFF; sv = sa + sb; arith = 1'b1;
        end
        OP_ADC: begin
          res = a + b + {31'b0, mflags[1]};
          c = ({1'b0, a} + {1'b0, b} + {32'b0, mflags[1]}) > 33'h0FFFFFFFF;
          sv = sa + sb + longint'(mflags[1]); arith = 1'b1;
        end
        default: res = 32'd0;
      endcase
    end
`ifdef ALU_SEQ_OVF_EN
    if (arith) v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
`endif
    nflags = s ? {res[31], (res == 32'd0), c, v} : mflags;
    alu_noise_c = ~mflags[1];
    alu_noise_v = ~mflags[0];

    bus.issue_cmd = cmd; bus.issue_cond = cond; bus.issue_set_flags = s;
    bus.issue_rd = rd; bus.issue_op1 = a; bus.issue_op2 = b; bus.issue_valid = 1'b1;
    chk("issue_ready_idle", {31'b0, bus.issue_ready}, 32'd1);
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    if (!pass) begin
      chk("squash_busy", {31'b0, busy}, 32'd0);
      chk("squash_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
      chk("squash_flags", {28'b0, flags}, {28'b0, mflags});
      chk("squash_ready", {31'b0, bus.issue_ready}, 32'd1);
      return;
    end
    ecyc = (cls == CLS_MUL) ? MUL_CYCLES : 1;
    for (int i = 0; i < ecyc; i++) begin
      chk("exec_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
      chk("exec_src1", bus.alu_src1, a);
      chk("exec_src2", bus.alu_src2, b);
      chk("exec_cmd", {24'b0, bus.alu_ctrl_cmd}, {24'b0, cmd});
      chk("exec_cur_flags", {28'b0, bus.alu_cur_flags}, {28'b0, mflags});
      chk("exec_ready", {31'b0, bus.issue_ready}, 32'd0);
      @(posedge clk); #1;
    end
    mflags = nflags;
    for (int d = 0; d < wb_delay; d++) begin
      bus.issue_valid = 1'b1;
      bus.issue_cond  = 4'hE;
      chk("wb_hold_valid", {31'b0, bus.wb_valid}, 32'd1);
      chk("wb_hold_data", bus.wb_data, res);
      chk("wb_hold_rd", {28'b0, bus.wb_rd}, {28'b0, rd});
      chk("wb_hold_ready", {31'b0, bus.issue_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.issue_valid = 1'b0;
    chk("wb_valid", {31'b0, bus.wb_valid}, 32'd1);
    chk("wb_data", bus.wb_data, res);
    chk("wb_rd", {28'b0, bus.wb_rd}, {28'b0, rd});
    chk("wb_flags", {28'b0, flags}, {28'b0, mflags});
    bus.wb_ready = 1'b1;
    @(posedge clk); #1;
    bus.wb_ready = 1'b0;
    chk("post_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
    chk("post_wb_ready", {31'b0, bus.issue_ready}, 32'd1);
    chk("post_wb_flags", {28'b0, flags}, {28'b0, mflags});
  endtask

  logic [3:0] ops [9];
  logic [31:0] specials [6];

  initial begin
    ops = '{OP_AND, OP_XOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_ORR, OP_BIC, OP_MVN};
    specials = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h5};
    bus.issue_valid = 1'b0; bus.issue_cmd = '0; bus.issue_cond = '0; bus.issue_set_flags = 1'b0;
    bus.issue_rd = '0; bus.issue_op1 = '0; bus.issue_op2 = '0; bus.wb_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {28'b0, flags}, 32'd0);
    chk("rst_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_wb_rd", {28'b0, bus.wb_rd}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_src1", bus.alu_src1, 32'd0);
    chk("rst_cmd", {24'b0, bus.alu_ctrl_cmd}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_instr(CLS_DP, OP_ADD, 4'hE, 1'b1, 4'd3, 32'hFFFFFFFF, 32'd1, 0);
    chk("add_wrap_flags", {28'b0, flags}, 32'b0110);
    run_instr(CLS_DP, OP_ADD, 4'hE, 1'b1, 4'd1, 32'd1, 32'd1, 0);
    chk("clear_flags", {28'b0, flags}, 32'b0000);
    run_instr(CLS_DP, OP_ADD, 4'h0, 1'b1, 4'd2, 32'd9, 32'd9, 0);
    run_instr(CLS_DP, OP_SUB, 4'hE, 1'b1, 4'd4, 32'd5, 32'd3, 0);
    run_instr(CLS_MUL, OP_MUL, 4'hE, 1'b1, 4'd9, 32'd7, 32'd6, 0);
    chk("mul_flags", {28'b0, flags}, 32'b0010);
    chk("mul_data", bus.wb_data, 32'd42);
    run_instr(CLS_DP, OP_ADD, 4'hE, 1'b0, 4'd7, 32'h1234, 32'h1111, 5);
    run_instr(CLS_DP, OP_ORR, 4'hE, 1'b1, 4'd5, 32'd0, 32'd0, 0);
    chk("orr_keeps_c", {28'b0, flags}, 32'b0110);
    run_instr(CLS_DP, OP_ADD, 4'hE, 1'b1, 4'd6, 32'h7FFFFFFF, 32'd1, 1);

    bus.issue_cmd = {CLS_MUL, 1'b0, OP_MUL, 1'b0}; bus.issue_cond = 4'hE;
    bus.issue_set_flags = 1'b1; bus.issue_op1 = 32'd3; bus.issue_op2 = 32'd3; bus.issue_valid = 1'b1;
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    chk("rst_mul_busy", {31'b0, busy}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mflags = 4'b0000;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_flags", {28'b0, flags}, 32'd0);
    chk("abort_ready", {31'b0, bus.issue_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_wb", {31'b0, bus.wb_valid}, 32'd0);
      @(posedge clk); #1;
    end

    for (int t = 0; t < 200; t++) begin
      logic [31:0] a, b;
      logic [1:0]  cls;
      a = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      cls = ($urandom_range(0, 3) == 0) ? CLS_MUL : CLS_DP;
      run_instr(cls, (cls == CLS_MUL) ? OP_MUL : ops[$urandom_range(0, 8)],
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), a, b, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
